instruction_fetch_unit: RTL and testbench

//  Bus initiator for the instruction ROM: drives address/chip_select/output_enable, samples the ROM data bus
//  and queues 32-bit instruction words with their PC for the decode stage.

---
 rtl/cpu_fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
// Optional feature macro used by the fetch unit: FETCH_PERF_CNT_EN.
package cpu_fetch_pkg;

   localparam int INSTR_W    = 32;
   localparam int ROM_DATA_W = 64;
   localparam int ADDR_W     = 32;
   localparam int ENTRY_W    = ADDR_W + INSTR_W;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t IDLE    = 2'd0;
   localparam fetch_state_t DRIVE   = 2'd1;
   localparam fetch_state_t CAPTURE = 2'd2;

   // pc occupies the upper half of a packed entry
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, word} entries for the decoder.
// Flush wins over push/pop; head reads as zero when empty.
module fetch_queue
   import cpu_fetch_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [ENTRY_W-1:0]       push_entry,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ENTRY_W-1:0]       head
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        count_q;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   // a push into a full queue is only taken when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)
            count_q <= count_q + 1'b1;
         else if (!do_push && do_pop)
            count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush)
         mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction ROM bus initiator: owns the PC, sequences ROM accesses and queues words for decode.
// Define FETCH_PERF_CNT_EN to build the completed-fetch counter; otherwise fetch_count reads zero.
module instruction_fetch_unit
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter int          SETTLE_CYCLES = 1,
   parameter int          QUEUE_DEPTH   = 2
)
(
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] rom_address,
   output logic        rom_chip_select,
   output logic        rom_output_enable,
   input  logic [63:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_word,
   output logic [31:0] instr_pc,
   output logic [31:0] fetch_count
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [SW-1:0]     settle_q, settle_d;

   logic               q_full;
   logic               q_empty;
   logic [CW-1:0]      q_count;
   logic [ENTRY_W-1:0] q_head;
   fetch_entry_t       push_entry;
   fetch_entry_t       head_entry;
   logic               push;
   logic               pop;
   logic               slot_free_now;
   logic               slot_free_after;
   logic               unused_rom_hi;

   assign unused_rom_hi = ^rom_data[ROM_DATA_W-1:INSTR_W];

   // a redirect discards both the in-flight word and any pop offered alongside it
   assign pop             = instr_valid && instr_ready && !redirect_valid;
   assign push            = (state_q == CAPTURE) && !redirect_valid;
   assign slot_free_now   = !q_full || pop;
   assign slot_free_after = (q_count < CW'(QUEUE_DEPTH - 1)) || pop;

   assign push_entry.pc   = pc_q;
   assign push_entry.word = rom_data[INSTR_W-1:0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      settle_d = settle_q;
      if (redirect_valid) begin
         state_d = IDLE;
         pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      end else begin
         case (state_q)
            IDLE: begin
               if (!halt && slot_free_now) begin
                  state_d  = DRIVE;
                  settle_d = SETTLE_LOAD;
               end
            end
            DRIVE: begin
               if (settle_q == '0)
                  state_d = CAPTURE;
               else
                  settle_d = settle_q - 1'b1;
            end
            CAPTURE: begin
               pc_d = pc_q + PC_STEP;
               if (!halt && slot_free_after) begin
                  state_d  = DRIVE;
                  settle_d = SETTLE_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         settle_q <= settle_d;
      end
   end

   assign rom_address       = pc_q;
   assign rom_chip_select   = (state_q != IDLE);
   assign rom_output_enable = (state_q != IDLE);

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count),
      .head       (q_head)
   );

   assign head_entry  = q_head;
   assign instr_valid = !q_empty;
   assign instr_pc    = head_entry.pc;
   assign instr_word  = head_entry.word;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         fetch_count_q <= '0;
      else if (push)
         fetch_count_q <= fetch_count_q + 1'b1;
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a small ROM program and an in-order PC model.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] rom_address;
   logic        rom_chip_select;
   logic        rom_output_enable;
   logic [63:0] rom_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_word;
   logic [31:0] instr_pc;
   logic [31:0] fetch_count;
   logic [31:0] junk = 32'h0;

   int checks = 0;
   int errors = 0;

   instruction_fetch_unit dut (
      .clock             (clock),
      .reset             (reset),
      .rom_address       (rom_address),
      .rom_chip_select   (rom_chip_select),
      .rom_output_enable (rom_output_enable),
      .rom_data          (rom_data),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .halt              (halt),
      .instr_valid       (instr_valid),
      .instr_ready       (instr_ready),
      .instr_word        (instr_word),
      .instr_pc          (instr_pc),
      .fetch_count       (fetch_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h00:  return 32'h910007E0;
         32'h04:  return 32'h910007E1;
         32'h08:  return 32'hF1003C04;
         32'h0C:  return 32'h8B020020;
         32'h10:  return 32'hCB030041;
         32'h14:  return 32'hB4000060;
         32'h18:  return 32'h17FFFFFA;
         32'h1C:  return 32'hD503201F;
         32'h20:  return 32'hD60003E0;
         default: return 32'h0;
      endcase
   endfunction

   // upper data lanes carry noise the fetch unit must ignore
   assign rom_data = (rom_chip_select && rom_output_enable) ? {junk, rom_word(rom_address)} : 64'h0;
   always @(posedge clock) junk <= $urandom;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clock);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      instr_ready    = rdy;
      @(negedge clock);
      @(negedge clock);
      chk("reset_valid", {31'h0, instr_valid}, 32'h0);
      chk("reset_cs", {30'h0, rom_chip_select, rom_output_enable}, 32'h0);
      chk("reset_addr", rom_address, 32'h0);
      chk("reset_head", instr_pc | instr_word, 32'h0);
      chk("reset_fcount", fetch_count, 32'h0);
      reset = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [31:0] epc, input logic [31:0] ew);
      int n = 0;
      instr_ready = 1'b1;
      while (!instr_valid && n < 50) begin
         cycle();
         n++;
      end
      if (!instr_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no instr_valid within 50 cycles, expected pc %08h", name, epc);
      end else begin
         chk({name, "_pc"}, instr_pc, epc);
         chk({name, "_word"}, instr_word, ew);
         cycle();
      end
   endtask

   typedef struct {
      logic        ready;
      logic        halt;
      logic        exp_valid;
      logic        exp_cs;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      logic [31:0] exp_word;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] exp_pc;
   logic [31:0] target;
   logic [31:0] exp_fc;
   logic        r_redirect;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 32'h0, 32'h910007E0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 32'h0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 32'h4, 32'h910007E1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 32'h0, 32'h0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 32'h8, 32'hF1003C04};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h0, 32'h0};

      // streaming from reset release, cycle by cycle
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) begin
         instr_ready = vecs[i].ready;
         halt        = vecs[i].halt;
         cycle();
         $display("vec %0d: valid=%0b cs=%0b addr=%08h pc=%08h word=%08h", i, instr_valid,
                  rom_chip_select, rom_address, instr_pc, instr_word);
         chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_cs", i), {31'h0, rom_chip_select}, {31'h0, vecs[i].exp_cs});
         chk($sformatf("vec%0d_oe", i), {31'h0, rom_output_enable}, {31'h0, vecs[i].exp_cs});
         chk($sformatf("vec%0d_addr", i), rom_address, vecs[i].exp_addr);
         chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_word", i), instr_word, vecs[i].exp_word);
      end

      // redirect during the CAPTURE of pc 0x0C: word discarded, target aligned
      redirect_valid = 1'b1;
      redirect_pc    = 32'h22;
      cycle();
      redirect_valid = 1'b0;
      $display("redirect 0x22: valid=%0b cs=%0b addr=%08h", instr_valid, rom_chip_select, rom_address);
      chk("redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("redir_cs", {30'h0, rom_chip_select, rom_output_enable}, 32'h0);
      chk("redir_addr", rom_address, 32'h20);
      pop_expect("redir_first", 32'h20, 32'hD60003E0);
      pop_expect("unmapped", 32'h24, 32'h0);

      // wrap of the PC at the top of the address space
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      pop_expect("wrap_top", 32'hFFFF_FFFC, 32'h0);
      pop_expect("wrap_zero", 32'h0, 32'h910007E0);
      $display("wrap sequence done");

      // decoder stalled from reset: queue fills, bus goes idle
      do_reset(1'b0);
      repeat (10) cycle();
`ifdef FETCH_PERF_CNT_EN
      exp_fc = 32'd2;
`else
      exp_fc = 32'd0;
`endif
      $display("stall fill: valid=%0b cs=%0b addr=%08h fcount=%0d", instr_valid, rom_chip_select,
               rom_address, fetch_count);
      chk("fill_valid", {31'h0, instr_valid}, 32'h1);
      chk("fill_cs", {30'h0, rom_chip_select, rom_output_enable}, 32'h0);
      chk("fill_pc", rom_address, 32'h8);
      chk("fill_fcount", fetch_count, exp_fc);
      pop_expect("drain0", 32'h0, 32'h910007E0);
      pop_expect("drain1", 32'h4, 32'h910007E1);
      pop_expect("drain2", 32'h8, 32'hF1003C04);

      // halt raised while DRIVE: the fetch finishes then the bus stays idle
      do_reset(1'b1);
      cycle();
      chk("halt_drive_cs", {31'h0, rom_chip_select}, 32'h1);
      halt = 1'b1;
      for (int k = 2; k <= 7; k++) begin
         cycle();
         $display("halt cycle %0d: cs=%0b valid=%0b pc=%08h", k, rom_chip_select, instr_valid, instr_pc);
         chk($sformatf("halt_cs%0d", k), {31'h0, rom_chip_select}, (k == 2) ? 32'h1 : 32'h0);
         if (k == 3) chk("halt_pushed_pc", instr_pc, 32'h0);
      end
      halt = 1'b0;
      cycle();
      chk("unhalt_cs", {31'h0, rom_chip_select}, 32'h1);
      chk("unhalt_addr", rom_address, 32'h4);
      pop_expect("unhalt_first", 32'h4, 32'h910007E1);

      // asynchronous reset pulse while the bus is active
      do_reset(1'b1);
      pop_expect("pre_pulse0", 32'h0, 32'h910007E0);
      pop_expect("pre_pulse1", 32'h4, 32'h910007E1);
      cycle();
      chk("pre_pulse_cs", {31'h0, rom_chip_select}, 32'h1);
      #2 reset = 1'b1;
      #1;
      $display("reset pulse: cs=%0b oe=%0b valid=%0b fcount=%0d", rom_chip_select, rom_output_enable,
               instr_valid, fetch_count);
      chk("pulse_cs", {30'h0, rom_chip_select, rom_output_enable}, 32'h0);
      chk("pulse_valid", {31'h0, instr_valid}, 32'h0);
      chk("pulse_fcount", fetch_count, 32'h0);
      chk("pulse_addr", rom_address, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      pop_expect("post_pulse", 32'h0, 32'h910007E0);

      // random traffic against an in-order PC model
      do_reset(1'b0);
      exp_pc = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         instr_ready = ($urandom_range(0, 9) < 7);
         halt        = ($urandom_range(0, 9) == 0);
         r_redirect  = ($urandom_range(0, 49) == 0);
         target      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 48));
         redirect_valid = r_redirect;
         redirect_pc    = target;
         #1;
         if (r_redirect) begin
            $display("rand %0d: redirect to %08h", c, target);
            exp_pc = target & 32'hFFFF_FFFC;
         end else if (instr_valid && instr_ready) begin
            $display("rand %0d: pop pc=%08h word=%08h", c, instr_pc, instr_word);
            chk("rand_pc", instr_pc, exp_pc);
            chk("rand_word", instr_word, rom_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end else if (!instr_valid) begin
            if ((instr_pc | instr_word) !== 32'h0) chk("rand_empty_head", instr_pc | instr_word, 32'h0);
         end
         if (rom_chip_select !== rom_output_enable)
            chk("rand_cs_oe", {31'h0, rom_output_enable}, {31'h0, rom_chip_select});
`ifndef FETCH_PERF_CNT_EN
         if (fetch_count !== 32'h0) chk("rand_fcount", fetch_count, 32'h0);
`endif
         cycle();
      end
      redirect_valid = 1'b0;
      halt           = 1'b0;
      pop_expect("rand_drain", exp_pc, rom_word(exp_pc));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
